// File: rtl/aes_iter_core.sv
// Iterative AES-128 encrypt/decrypt core with configurable S-box and MixColumns lane counts.
// The key schedule is derived combinationally from the captured key and is used after KEY_LAT cycles.
module aes_iter_core #(
  parameter int SB_LANES = 16,
  parameter int MC_LANES = 1,
  parameter int KEY_LAT  = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_key,
  input  logic [127:0] in_data,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_mode,
  output logic         busy
);

  localparam int SBW       = 8 * SB_LANES;
  localparam int SB_GROUPS = 16 / SB_LANES;
  localparam int MCW       = 32 * MC_LANES;
  localparam int MC_GROUPS = 4 / MC_LANES;
  localparam logic [1:0] SB_LAST = 2'(SB_GROUPS - 1);
  localparam logic [1:0] MC_LAST = 2'(MC_GROUPS - 1);
  localparam logic [7:0] KW_LAST = 8'(KEY_LAT - 1);

  if (!(SB_LANES == 4 || SB_LANES == 8 || SB_LANES == 16)) begin : g_bad_sb_lanes
    $error("aes_iter_core: SB_LANES must be 4, 8 or 16");
  end
  if (!(MC_LANES == 1 || MC_LANES == 2 || MC_LANES == 4)) begin : g_bad_mc_lanes
    $error("aes_iter_core: MC_LANES must be 1, 2 or 4");
  end
  if (KEY_LAT < 1 || KEY_LAT > 256) begin : g_bad_key_lat
    $error("aes_iter_core: KEY_LAT must be in 1..256");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_KEYWAIT, S_ARK0, S_SUB, S_SHIFT, S_MIX, S_ARK, S_DONE
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h01;
    x = a;
    for (int i = 1; i < 8; i++) begin
      x = gmul(x, x);
      r = gmul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n of the block sits at [127-8n -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = 128'h0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * src) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] a [0:3];
    logic [7:0] m0, m1, m2, m3;
    logic [31:0] o;
    for (int i = 0; i < 4; i++) a[i] = c[31 - 8 * i -: 8];
    m0 = inv ? 8'h0e : 8'h02;
    m1 = inv ? 8'h0b : 8'h03;
    m2 = inv ? 8'h0d : 8'h01;
    m3 = inv ? 8'h09 : 8'h01;
    o = 32'h0;
    for (int i = 0; i < 4; i++) begin
      o[31 - 8 * i -: 8] = gmul(a[i], m0) ^ gmul(a[(i + 1) % 4], m1) ^
                           gmul(a[(i + 2) % 4], m2) ^ gmul(a[(i + 3) % 4], m3);
    end
    return o;
  endfunction

  // Round key k occupies bits [128k +: 128] of the 1408-bit schedule.
  function automatic logic [1407:0] key_sched(input logic [127:0] key);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] ks;
    rcon = 8'h01;
    ks   = 1408'h0;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[128 * (i / 4) + 32 * (3 - i % 4) +: 32] = w[i];
    return ks;
  endfunction

  fsm_t           fsm_r;
  logic [127:0]   key_r, state_r, shadow_r;
  logic           mode_r;
  logic [3:0]     round_r;
  logic [1:0]     lane_r;
  logic [7:0]     kw_r;
  logic [1407:0]  sched;
  logic [3:0]     rk_idx;
  logic [127:0]   ark_out;
  logic [SBW-1:0] sub_in, sub_out;
  logic [MCW-1:0] mix_in, mix_out;
  logic [127:0]   sub_full, mix_full;

  assign sched = key_sched(key_r);

  // Round-key selection for the initial and per-round AddRoundKey steps
  always_comb begin
    rk_idx = 4'd0;
    if (fsm_r == S_ARK0) begin
      rk_idx = mode_r ? 4'd0 : 4'd10;
    end else begin
      rk_idx = mode_r ? round_r : (4'd10 - round_r);
    end
    ark_out = state_r ^ sched[{rk_idx, 7'd0} +: 128];
  end

  // Lane-sliced SubBytes and MixColumns; the current group is merged into the shadow copy
  always_comb begin
    sub_in   = {SBW{1'b0}};
    sub_out  = {SBW{1'b0}};
    sub_full = shadow_r;
    mix_in   = {MCW{1'b0}};
    mix_out  = {MCW{1'b0}};
    mix_full = shadow_r;
    for (int g = 0; g < SB_GROUPS; g++) sub_in = (lane_r == 2'(g)) ? state_r[g * SBW +: SBW] : sub_in;
    for (int b = 0; b < SB_LANES; b++) begin
      sub_out[8 * b +: 8] = mode_r ? sbox(sub_in[8 * b +: 8]) : inv_sbox(sub_in[8 * b +: 8]);
    end
    for (int g = 0; g < SB_GROUPS; g++) begin
      sub_full[g * SBW +: SBW] = (lane_r == 2'(g)) ? sub_out : shadow_r[g * SBW +: SBW];
    end
    for (int g = 0; g < MC_GROUPS; g++) mix_in = (lane_r == 2'(g)) ? state_r[g * MCW +: MCW] : mix_in;
    for (int k = 0; k < MC_LANES; k++) mix_out[32 * k +: 32] = mix_col(mix_in[32 * k +: 32], !mode_r);
    for (int g = 0; g < MC_GROUPS; g++) begin
      mix_full[g * MCW +: MCW] = (lane_r == 2'(g)) ? mix_out : shadow_r[g * MCW +: MCW];
    end
  end

  // Control FSM, datapath registers and registered handshake outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fsm_r     <= S_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 128'h0;
      out_mode  <= 1'b0;
      round_r   <= 4'd0;
      lane_r    <= 2'd0;
      kw_r      <= 8'd0;
      mode_r    <= 1'b0;
      key_r     <= 128'h0;
      state_r   <= 128'h0;
      shadow_r  <= 128'h0;
    end else if (abort && fsm_r != S_IDLE && fsm_r != S_DONE) begin
      fsm_r    <= S_IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      round_r  <= 4'd0;
      lane_r   <= 2'd0;
      kw_r     <= 8'd0;
    end else begin
      case (fsm_r)
        S_IDLE: if (in_valid) begin
          key_r    <= in_key;
          state_r  <= in_data;
          mode_r   <= in_mode;
          round_r  <= 4'd0;
          lane_r   <= 2'd0;
          kw_r     <= 8'd0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          fsm_r    <= S_KEYWAIT;
        end
        S_KEYWAIT: if (kw_r == KW_LAST) fsm_r <= S_ARK0; else kw_r <= kw_r + 8'd1;
        S_ARK0: begin
          state_r <= ark_out;
          round_r <= 4'd1;
          fsm_r   <= mode_r ? S_SUB : S_SHIFT;
        end
        S_SUB: begin
          shadow_r <= sub_full;
          if (lane_r == SB_LAST) begin
            state_r <= sub_full;
            lane_r  <= 2'd0;
            fsm_r   <= mode_r ? S_SHIFT : S_ARK;
          end else begin
            lane_r <= lane_r + 2'd1;
          end
        end
        S_SHIFT: begin
          state_r <= shift_rows(state_r, !mode_r);
          if (!mode_r) fsm_r <= S_SUB;
          else if (round_r == 4'd10) fsm_r <= S_ARK;
          else fsm_r <= S_MIX;
        end
        S_MIX: begin
          shadow_r <= mix_full;
          if (lane_r == MC_LAST) begin
            state_r <= mix_full;
            lane_r  <= 2'd0;
            if (mode_r) begin
              fsm_r <= S_ARK;
            end else begin
              fsm_r   <= S_SHIFT;
              round_r <= round_r + 4'd1;
            end
          end else begin
            lane_r <= lane_r + 2'd1;
          end
        end
        S_ARK: begin
          state_r <= ark_out;
          if (round_r == 4'd10) begin
            out_data  <= ark_out;
            out_mode  <= mode_r;
            out_valid <= 1'b1;
            fsm_r     <= S_DONE;
          end else if (mode_r) begin
            round_r <= round_r + 4'd1;
            fsm_r   <= S_SUB;
          end else begin
            fsm_r <= S_MIX;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          round_r   <= 4'd0;
          fsm_r     <= S_IDLE;
        end
        default: fsm_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
- Parametrised iterative AES-128 core. Encrypts or decrypts one 128-bit block per request; mode is selected per block.
- Successor to the fixed decrypt-only core. Adds:
  - forward (encrypt) mode;
  - configurable S-box and MixColumns lane counts;
  - valid/ready handshakes on input and output;
  - abort.
- Sits between the Avalon register front-end and the round-function library: SubBytes/InvSubBytes, ShiftRows/InvShiftRows, MixColumns/InvMixColumns, and the KeyExpansion schedule generator.

Parameters:
- SB_LANES, 16, number of S-box byte lanes per cycle. Legal values 4, 8, 16. SubBytes step takes 16/SB_LANES cycles.
- MC_LANES, 1, number of MixColumns column lanes per cycle. Legal values 1, 2, 4. MixColumns step takes 4/MC_LANES cycles.
- KEY_LAT, 2, cycles from key capture until the full 1408-bit schedule from KeyExpansion is valid.

Ports:
- CLK, input, 1, clock; all state updates on the rising edge.
- RESET, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, request present.
- in_ready, output, 1, core can accept a request; high only in IDLE.
- in_mode, input, 1, 0 = decrypt, 1 = encrypt.
- in_key, input, 128, cipher key.
- in_data, input, 128, ciphertext or plaintext.
- abort, input, 1, synchronous abort of the current operation.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result.
- out_data, output, 128, result block.
- out_mode, output, 1, mode of the result held on out_data.
- busy, output, 1, high in every state other than IDLE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_mode=0, busy=0, round counter=0, lane counter=0. Reset asserted mid-operation discards everything; no partial result appears.
- Accept: in_valid & in_ready at an edge captures in_data, in_key and in_mode into internal registers. State goes to KEYWAIT. Port values after the accept edge are ignored.
- States:
  - IDLE
  - KEYWAIT: KEY_LAT cycles.
  - ARK0: one cycle. Adds key word 0 when encrypting, key word 10 when decrypting.
  - Round steps, in this order:
    - Encrypt: SB, SR, MC, ARK.
    - Decrypt: ISR, ISB, ARK, IMC.
  - DONE
- Step timing:
  - SR/ISR: 1 cycle.
  - ARK: 1 cycle.
  - SB/ISB: 16/SB_LANES cycles. Lane counter selects byte groups starting at bits [8*SB_LANES-1:0], ascending.
  - MC/IMC: 4/MC_LANES cycles. Columns processed from [31:0] upward.
  - State register updates only on the last cycle of each step. Partial results are held in a shadow register.
- Round counter r runs 1..10.
  - Encrypt: ARK uses key word r.
  - Decrypt: ARK uses key word 10-r.
- Round 10 omits MC/IMC. After round-10 ARK:
  - out_data and out_mode are loaded;
  - out_valid is set;
  - state goes to DONE.
- Latency from accept edge to the edge setting out_valid: L = 1 + KEY_LAT + 1 + 10*(2 + 16/SB_LANES) + 9*(4/MC_LANES) − 1. With defaults this is 69 cycles. Identical for both modes.
- DONE: out_valid and out_data are held stable until out_ready.
  - out_valid & out_ready at an edge → IDLE, out_valid=0. out_data retains its last value.
  - in_ready is 0 in DONE, so no new accept overlaps. A new request can be accepted on the first IDLE cycle.
- abort:
  - In any state other than IDLE or DONE: at the next edge go to IDLE; round and lane counters cleared; no out_valid pulse.
  - In DONE: ignored; the result is not lost.
  - In IDLE: no effect. If asserted in the same cycle as an accept, the accept wins.
- A held out_ready while out_valid=0 has no effect.
- Parameter values outside the legal sets cause an elaboration error (generate-time check).

Test Plan:
- FIPS-197 C.1 encrypt, defaults: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, mode 1 → out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_mode 1, out_valid exactly 69 cycles after the accept edge.
- Decrypt of the same key and data 69c4e0d86a7b0430d8cdb78070b4c55a, mode 0 → 00112233445566778899aabbccddeeff at the same latency. Repeat with SB_LANES=4, MC_LANES=4, KEY_LAT=2 → same result, out_valid 1+2+1+10*6+9*1−1 = 72 cycles after accept.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid → out_data stable, in_ready=0, busy=1. Raise out_ready → IDLE next edge. A back-to-back request accepted on the following cycle completes correctly.
- Abort at cycle 30 of an encrypt → IDLE, in_ready=1, no out_valid. The next request with the C.1 vector produces the correct ciphertext.
- Async RESET pulsed between clock edges mid-decrypt → all outputs take reset values immediately with no clock. After release, the C.1 decrypt completes correctly.
- Mode interleave: encrypt, then decrypt with a different key, e.g. 2b7e151628aed2a6abf7158809cf4f3c with data 3ad77bb40d7a3660a89ecaf32466ef97 → 6bc1bee22e409f96e93d7e117393172a, out_mode 0.
